rv_alu_unit: RTL and testbench

RV32I execute-stage arithmetic block. It decodes opcode, funct3 and the funct7[5] bit (add_rshift_type) into a 4-bit ALU operation and computes a 32-bit result from operands A and B. The result is combinational, and a registered copy is also provided for pipelines that capture it at the clock edge. Operand muxing (PC vs rs1, immediate vs rs2) is done upstream, outside this block.

---
 rtl/rv_alu_unit_pkg.sv | 58 +++++
 rtl/rv_alu_core.sv | 35 +++
 rtl/rv_alu_decode.sv | 26 ++
 rtl/rv_alu_unit.sv | 44 ++++
 tb/tb_rv_alu_unit.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_alu_unit_pkg.sv
// Shared constants for the RV32I execute-stage ALU: opcodes, funct3 codes,
// the 4-bit ALU operation encoding and the funct3-to-operation helper.
package rv_alu_unit_pkg;

  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_ARI_RTYPE = 7'b0110011;
  localparam logic [6:0] OPC_ARI_ITYPE = 7'b0010011;
  localparam logic [6:0] OPC_CSR       = 7'b1110011;
  localparam logic [6:0] OPC_NOOP      = 7'b0000000;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_AND    = 4'd2,
    ALU_OR     = 4'd3,
    ALU_XOR    = 4'd4,
    ALU_SLT    = 4'd5,
    ALU_SLTU   = 4'd6,
    ALU_SLL    = 4'd7,
    ALU_SRA    = 4'd8,
    ALU_SRL    = 4'd9,
    ALU_COPY_B = 4'd10,
    ALU_COPY_A = 4'd11,
    ALU_ZERO   = 4'd15
  } alu_op_t;

  // allow_sub is clear for I-type, where funct3 000 is always ADD.
  function automatic alu_op_t arith_op(input logic [2:0] f3, input logic alt,
                                       input logic allow_sub);
    case (f3)
      F3_ADD_SUB: return (allow_sub && alt) ? ALU_SUB : ALU_ADD;
      F3_SLL:     return ALU_SLL;
      F3_SLT:     return ALU_SLT;
      F3_SLTU:    return ALU_SLTU;
      F3_XOR:     return ALU_XOR;
      F3_SRL_SRA: return alt ? ALU_SRA : ALU_SRL;
      F3_OR:      return ALU_OR;
      F3_AND:     return ALU_AND;
      default:    return ALU_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/rv_alu_core.sv
// Combinational 32-bit ALU datapath; shifts use only b[4:0].
module rv_alu_core
  import rv_alu_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_t          alu_op,
  output logic [WIDTH-1:0] result
);

  logic [4:0] shamt;
  assign shamt = b[4:0];

  always_comb begin
    result = '0;
    case (alu_op)
      ALU_ADD:    result = a + b;
      ALU_SUB:    result = a - b;
      ALU_AND:    result = a & b;
      ALU_OR:     result = a | b;
      ALU_XOR:    result = a ^ b;
      ALU_SLT:    result = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU:   result = {{(WIDTH-1){1'b0}}, a < b};
      ALU_SLL:    result = a << shamt;
      ALU_SRA:    result = $unsigned($signed(a) >>> shamt);
      ALU_SRL:    result = a >> shamt;
      ALU_COPY_B: result = b;
      ALU_COPY_A: result = a;
      default:    result = '0;
    endcase
  end

endmodule

// File: rtl/rv_alu_decode.sv
// Opcode/funct3/inst[30] to ALU operation. Opcode is decoded first so that
// funct and add_rshift_type are never looked at for opcodes that ignore them.
module rv_alu_decode
  import rv_alu_unit_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct,
  input  logic       add_rshift_type,
  output alu_op_t    alu_op
);

  always_comb begin
    // NOTE: default assignment first so every path is covered and no latch is inferred.
    alu_op = ALU_ZERO;
    case (opcode)
      OPC_LUI:                                    alu_op = ALU_COPY_B;
      OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
      OPC_LOAD, OPC_STORE:                        alu_op = ALU_ADD;
      OPC_ARI_RTYPE: alu_op = arith_op(funct, add_rshift_type, 1'b1);
      OPC_ARI_ITYPE: alu_op = arith_op(funct, add_rshift_type, 1'b0);
      OPC_CSR:                                    alu_op = ALU_COPY_A;
      default:                                    alu_op = ALU_ZERO;
    endcase
  end

endmodule

// File: rtl/rv_alu_unit.sv
// RV32I execute-stage ALU: decode plus datapath, with a registered copy of the
// combinational result for pipelines that capture it at the clock edge.
module rv_alu_unit
  import rv_alu_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct,
  input  logic             add_rshift_type,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [3:0]       ALUop,
  output logic [WIDTH-1:0] Out,
  output logic [WIDTH-1:0] Out_q
);

  alu_op_t alu_op;

  rv_alu_decode u_decode (
    .opcode          (opcode),
    .funct           (funct),
    .add_rshift_type (add_rshift_type),
    .alu_op          (alu_op)
  );

  rv_alu_core #(.WIDTH(WIDTH)) u_core (
    .a      (A),
    .b      (B),
    .alu_op (alu_op),
    .result (Out)
  );

  assign ALUop = alu_op;

  always_ff @(posedge Clock) begin
    // NOTE: non-blocking assignment for registered state avoids simulation ordering races.
    if (Reset) Out_q <= '0;
    else       Out_q <= Out;
  end

endmodule

// File: tb/tb_rv_alu_unit.sv
// Self-checking bench for rv_alu_unit: directed cases plus randomized
// stimulus against a behavioural reference model.
module tb_rv_alu_unit;
  import rv_alu_unit_pkg::*;

  logic        clk;
  logic        rst;
  logic [6:0]  opcode;
  logic [2:0]  funct;
  logic        alt;
  logic [31:0] a, b;
  logic [3:0]  alu_op;
  logic [31:0] out, out_q;

  int pass_cnt = 0;
  int total_cnt = 0;

  rv_alu_unit dut (
    .Clock           (clk),
    .Reset           (rst),
    .opcode          (opcode),
    .funct           (funct),
    .add_rshift_type (alt),
    .A               (a),
    .B               (b),
    .ALUop           (alu_op),
    .Out             (out),
    .Out_q           (out_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  op7;
    logic [2:0]  f3;
    logic        alt;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  // Reference model: operation code and result, straight from the ISA rules.
  function automatic logic [3:0] ref_op(logic [6:0] op7, logic [2:0] f3, logic al);
    logic [3:0] arith [8];
    arith = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd9, 4'd3, 4'd2};
    if (op7 == OPC_LUI) return 4'd10;
    if (op7 == OPC_CSR) return 4'd11;
    if (op7 inside {OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE})
      return 4'd0;
    if (op7 == OPC_ARI_RTYPE || op7 == OPC_ARI_ITYPE) begin
      if (f3 == 3'd0 && al && op7 == OPC_ARI_RTYPE) return 4'd1;
      if (f3 == 3'd5 && al) return 4'd8;
      return arith[f3];
    end
    return 4'd15;
  endfunction

  function automatic logic [31:0] ref_out(logic [3:0] op, logic [31:0] x, logic [31:0] y);
    longint unsigned sh;
    logic [63:0]     ext;
    sh  = longint'(y[4:0]);
    ext = {{32{x[31]}}, x};
    case (op)
      4'd0:  return x + y;
      4'd1:  return x + ~y + 32'd1;
      4'd2:  return x & y;
      4'd3:  return x | y;
      4'd4:  return x ^ y;
      4'd5:  return (int'(x) < int'(y)) ? 32'd1 : 32'd0;
      4'd6:  return ({1'b0, x} < {1'b0, y}) ? 32'd1 : 32'd0;
      4'd7:  return 32'(longint'(x) * (64'd1 << sh));
      4'd8:  return 32'(ext >> sh);
      4'd9:  return 32'(longint'(x) / (64'd1 << sh));
      4'd10: return y;
      4'd11: return x;
      default: return 32'd0;
    endcase
  endfunction

  task automatic drive(logic [6:0] op7, logic [2:0] f3, logic al,
                       logic [31:0] x, logic [31:0] y);
    @(negedge clk);
    opcode = op7; funct = f3; alt = al; a = x; b = y;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(OPC_LOAD, 3'd0, 1'b0, 32'd7, 32'd8);
    total_cnt++;
    if (out !== 32'd15) $display("FAIL reset_comb out=%h exp=%h", out, 32'd15);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (out_q !== 32'd0) $display("FAIL reset_outq out_q=%h exp=%h", out_q, 32'd0);
    else pass_cnt++;
  endtask

  task automatic test_register();
    @(negedge clk);
    rst = 1'b0;
    drive(OPC_LOAD, 3'($urandom), 1'($urandom), 32'd1, 32'd2);
    total_cnt++;
    if (out !== 32'd3) $display("FAIL reg_comb out=%h exp=%h", out, 32'd3);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (out_q !== 32'd3) $display("FAIL reg_capture out_q=%h exp=%h", out_q, 32'd3);
    else pass_cnt++;
    drive(OPC_ARI_RTYPE, 3'd6, 1'b0, 32'h0F00, 32'h00F0);
    rst = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if (out_q !== 32'd0) $display("FAIL reg_midreset out_q=%h exp=%h", out_q, 32'd0);
    else pass_cnt++;
    total_cnt++;
    if (out !== 32'h0FF0) $display("FAIL reg_comb_in_reset out=%h exp=%h", out, 32'h0FF0);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    total_cnt++;
    if (out_q !== 32'h0FF0) $display("FAIL reg_after_release out_q=%h exp=%h", out_q, 32'h0FF0);
    else pass_cnt++;
  endtask

  task automatic test_table(string name, vec_t v[]);
    foreach (v[i]) begin
      drive(v[i].op7, v[i].f3, v[i].alt, v[i].a, v[i].b);
      total_cnt++;
      if (out !== v[i].exp)
        $display("FAIL %s[%0d] out=%h exp=%h", name, i, out, v[i].exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_shifts();
    vec_t v[];
    v = new[6];
    v[0] = '{OPC_ARI_RTYPE, 3'd1, 1'($urandom), 32'd5, 32'd0,          32'h00000005};
    v[1] = '{OPC_ARI_RTYPE, 3'd1, 1'b0,         32'd5, 32'hFFFFFFFB,   32'h28000000};
    v[2] = '{OPC_ARI_RTYPE, 3'd5, 1'b1,         32'd5, 32'hFFFFFFFB,   32'h00000000};
    v[3] = '{OPC_ARI_RTYPE, 3'd5, 1'b1, 32'h80000000, 32'hFFFF8000,   32'h80000000};
    v[4] = '{OPC_ARI_ITYPE, 3'd5, 1'b1, 32'h80000000, 32'd4,          32'hF8000000};
    v[5] = '{OPC_ARI_ITYPE, 3'd5, 1'b0, 32'h80000000, 32'd4,          32'h08000000};
    test_table("shift", v);
  endtask

  task automatic test_addsub();
    vec_t v[];
    v = new[3];
    v[0] = '{OPC_ARI_RTYPE, 3'd0, 1'b0, 32'd5, 32'hFFFFFFFB, 32'h00000000};
    v[1] = '{OPC_ARI_RTYPE, 3'd0, 1'b1, 32'd5, 32'hFFFFFFFB, 32'h0000000A};
    v[2] = '{OPC_ARI_ITYPE, 3'd0, 1'b1, 32'd5, 32'hFFFFFFFB, 32'h00000000};
    test_table("addsub", v);
  endtask

  task automatic test_compare();
    vec_t v[];
    v = new[3];
    v[0] = '{OPC_ARI_RTYPE, 3'd2, 1'b0, 32'h80000000, 32'hFFFF8000, 32'd1};
    v[1] = '{OPC_ARI_RTYPE, 3'd3, 1'b0, 32'h80000000, 32'hFFFF8000, 32'd1};
    v[2] = '{OPC_ARI_RTYPE, 3'd2, 1'b0, 32'h00000001, 32'hFFFFFFFF, 32'd0};
    test_table("compare", v);
  endtask

  task automatic test_passthrough();
    vec_t v[];
    v = new[3];
    v[0] = '{OPC_LUI, 3'($urandom), 1'($urandom), 32'h0BADF00D, 32'h12345000, 32'h12345000};
    v[1] = '{OPC_CSR, 3'd1, 1'b0, 32'hDEADBEEF, 32'h00001111, 32'hDEADBEEF};
    v[2] = '{OPC_CSR, 3'd5, 1'b1, 32'hDEADBEEF, 32'h00002222, 32'hDEADBEEF};
    test_table("pass", v);
  endtask

  task automatic test_noop();
    @(negedge clk);
    opcode = OPC_NOOP; funct = 'x; alt = 'x; a = 32'hFFFFFFFF; b = 32'h12345678;
    #1;
    total_cnt++;
    if (out !== 32'd0) $display("FAIL noop_out out=%h exp=%h", out, 32'd0);
    else pass_cnt++;
    total_cnt++;
    if (alu_op !== 4'd15) $display("FAIL noop_aluop aluop=%h exp=%h", alu_op, 4'd15);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [6:0] ops [11];
    logic [6:0] op7;
    logic [3:0] eop;
    logic [31:0] eout;
    int errs;
    ops = '{OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE,
            OPC_ARI_RTYPE, OPC_ARI_ITYPE, OPC_CSR, OPC_NOOP};
    errs = 0;
    for (int i = 0; i < 400; i++) begin
      int k;
      k = int'($urandom_range(0, 13));
      op7 = (k < 11) ? ops[k] : 7'($urandom);
      if (k >= 11 && op7 inside {OPC_ARI_RTYPE, OPC_ARI_ITYPE}) op7 = OPC_ARI_RTYPE;
      drive(op7, 3'($urandom), 1'($urandom), $urandom, ($urandom_range(0, 3) == 0) ?
            32'($urandom_range(0, 40)) : $urandom);
      eop  = ref_op(opcode, funct, alt);
      eout = ref_out(eop, a, b);
      total_cnt++;
      if (alu_op !== eop) begin
        if (errs < 10) $display("FAIL rand_aluop op=%b f3=%0d alt=%b aluop=%0d exp=%0d",
                                opcode, funct, alt, alu_op, eop);
        errs++;
      end else pass_cnt++;
      total_cnt++;
      if (out !== eout) begin
        if (errs < 10) $display("FAIL rand_out op=%b f3=%0d alt=%b a=%h b=%h out=%h exp=%h",
                                opcode, funct, alt, a, b, out, eout);
        errs++;
      end else pass_cnt++;
      @(posedge clk); #1;
      total_cnt++;
      if (out_q !== eout) begin
        if (errs < 10) $display("FAIL rand_outq out_q=%h exp=%h", out_q, eout);
        errs++;
      end else pass_cnt++;
    end
  endtask

  initial begin
    rst = 1'b1; opcode = OPC_NOOP; funct = 3'd0; alt = 1'b0; a = '0; b = '0;
    test_reset();
    test_register();
    test_shifts();
    test_addsub();
    test_compare();
    test_passthrough();
    test_noop();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
